// File: rtl/otp_access_sequencer.sv
// rtl/otp_access_sequencer.sv - round-robin two-port arbiter and setup/strobe/hold sequencer for the OTP macro
module otp_access_sequencer #(
  parameter int AW      = 10,
  parameter int DW      = 8,
  parameter int CNT_W   = 8,
  parameter int T_SETUP = 2,
  parameter int T_RD    = 4,
  parameter int T_PGM   = 100,
  parameter int T_HOLD  = 2
) (
  input  logic          CP,
  input  logic          CDN,
  input  logic          prog_en,
  input  logic          r0_req,
  input  logic          r0_wr,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  input  logic          r1_req,
  input  logic          r1_wr,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic          otp_ce,
  output logic          otp_cg_en,
  output logic [AW-1:0] otp_addr,
  output logic [DW-1:0] otp_din,
  output logic          otp_rd,
  output logic          otp_pgm,
  input  logic [DW-1:0] otp_dout
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK, REFUSE} state_t;

  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP);
  localparam logic [CNT_W-1:0] C_RD    = CNT_W'(T_RD);
  localparam logic [CNT_W-1:0] C_PGM   = CNT_W'(T_PGM);
  localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             acc_wr;
  logic             last_grant;
  logic             win;
  logic             win_wr;
  logic             last_cnt;

  // Contention goes to whoever was not granted last; a lone request always wins.
  always_comb begin
    win      = (r0_req && r1_req) ? ~last_grant : r1_req;
    win_wr   = win ? r1_wr : r0_wr;
    last_cnt = (cnt == C_ONE);
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      acc_wr     <= 1'b0;
      last_grant <= 1'b1;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      otp_ce     <= 1'b0;
      otp_cg_en  <= 1'b0;
      otp_addr   <= '0;
      otp_din    <= '0;
      otp_rd     <= 1'b0;
      otp_pgm    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            owner      <= win;
            last_grant <= win;
            acc_wr     <= win_wr;
            otp_addr   <= win ? r1_addr : r0_addr;
            otp_din    <= win ? r1_wdata : r0_wdata;
            busy       <= 1'b1;
            if (win_wr && !prog_en) begin
              state  <= REFUSE;
              err    <= 1'b1;
              r0_ack <= ~win;
              r1_ack <= win;
            end else begin
              state     <= SETUP;
              otp_ce    <= 1'b1;
              otp_cg_en <= 1'b1;
              cnt       <= C_SETUP;
            end
          end
        end
        SETUP: begin
          if (last_cnt) begin
            state   <= STROBE;
            cnt     <= acc_wr ? C_PGM : C_RD;
            otp_pgm <= acc_wr;
            otp_rd  <= ~acc_wr;
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        STROBE: begin
          if (last_cnt) begin
            state   <= HOLD;
            cnt     <= C_HOLD;
            otp_rd  <= 1'b0;
            otp_pgm <= 1'b0;
            if (!acc_wr) rdata <= otp_dout;
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        HOLD: begin
          if (last_cnt) begin
            state     <= ACK;
            otp_ce    <= 1'b0;
            otp_cg_en <= 1'b0;
            r0_ack    <= ~owner;
            r1_ack    <= owner;
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        // Returning through a non-granting IDLE cycle spaces grants at least two cycles apart.
        ACK, REFUSE: begin
          state  <= IDLE;
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          err    <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/otp_access_sequencer.md
Name: otp_access_sequencer

Overview:
Two-requester arbiter and timing sequencer for the OTP macro port. It grants one access at a time, round-robin, and drives the macro chip-enable, the clock-gate enable (E pin of the CKLNQD8 macro-clock gate), address, program data and read/program strobes with parameterised setup, strobe and hold windows. It captures read data, returns a one-cycle ack to the winning requester, and blocks programming unless the global program enable is set.

Parameters:
AW, 10, address width
DW, 8, data width
CNT_W, 8, timing counter width
T_SETUP, 2, cycles with CE/address stable before the strobe (1..2^CNT_W-1)
T_RD, 4, read strobe width in cycles (1..2^CNT_W-1)
T_PGM, 100, program strobe width in cycles (1..2^CNT_W-1)
T_HOLD, 2, cycles with CE/address held after the strobe falls (1..2^CNT_W-1)

Ports:
CP  in  1  clock, rising edge
CDN  in  1  asynchronous active-low reset
prog_en  in  1  global program enable; sampled at grant
r0_req  in  1  requester 0 request; held until r0_ack
r0_wr  in  1  1=program, 0=read
r0_addr  in  AW  requester 0 address
r0_wdata  in  DW  requester 0 program data
r0_ack  out  1  one-cycle completion pulse
r1_req, r1_wr, r1_addr, r1_wdata, r1_ack  same as r0 for requester 1
rdata  out  DW  read data; valid while either ack is high, held until the next read capture
err  out  1  high with ack when a program request was refused
busy  out  1  high in every state except IDLE
otp_ce  out  1  macro chip enable
otp_cg_en  out  1  macro clock-gate enable
otp_addr  out  AW  macro address
otp_din  out  DW  macro program data
otp_rd  out  1  macro read strobe
otp_pgm  out  1  macro program strobe
otp_dout  in  DW  macro read data

Behaviour:
- Reset (CDN=0, asynchronous): state=IDLE, all outputs 0, counters 0, last_grant=1 (so r0 wins first). otp_pgm and otp_rd fall with CDN immediately; no synchronous path is required.
- All macro-facing outputs, ack, err and busy come straight from flops. There are no combinational paths from inputs to outputs.
- States: IDLE, SETUP, STROBE, HOLD, ACK, REFUSE.
- IDLE: if any req is high, choose a winner.
  - Only one req high: that requester wins.
  - Both high: the requester other than last_grant wins.
  - Latch owner, wr, addr and wdata into otp_addr/otp_din, and set last_grant=owner.
  - If wr=1 and prog_en=0: go to REFUSE.
  - Otherwise: set otp_ce=1 and otp_cg_en=1, load the counter with T_SETUP, go to SETUP.
- SETUP: decrement the counter each cycle. On the last count, load T_RD or T_PGM, assert otp_rd or otp_pgm, go to STROBE.
- STROBE: the strobe stays high for exactly T_RD or T_PGM cycles.
  - Read: otp_dout is captured into rdata on the final strobe cycle's edge.
  - On expiry: drop the strobe, load T_HOLD, go to HOLD.
- HOLD: otp_ce, otp_cg_en and otp_addr stay stable for T_HOLD cycles. On expiry: otp_ce=0, otp_cg_en=0, owner ack=1, go to ACK.
- ACK: lasts one cycle, then IDLE. The owner must drop req in the cycle after ack. IDLE never re-grants in the same cycle it is entered from ACK/REFUSE, so at most one grant occurs every 2 cycles.
- REFUSE: ack=1 and err=1 for one cycle; the macro is never touched and rdata is unchanged; then IDLE.
- Latency from the edge that samples req to ack high:
  - read: T_SETUP+T_RD+T_HOLD+1 edges (defaults: 9)
  - program: T_SETUP+T_PGM+T_HOLD+1 edges
  - refused program: 1 edge
- Request inputs, prog_en and a non-owner req are ignored outside IDLE. Requester signals changing mid-access do not affect otp_addr/otp_din.
- otp_rd and otp_pgm are never high together, and never high while otp_ce=0.
- Reset mid-access: the access is lost, no ack is issued, and the requester reissues it.

Test Plan:
- Reset with CDN=0 at random times, including mid-STROBE of a program -> otp_pgm, otp_ce and all acks go 0 asynchronously, before the next CP edge; after release a new r0 request is granted first.
- r0 read, addr=0x155, otp_dout=0xA5 -> otp_ce high 2+4+2 cycles; otp_rd high exactly 4 cycles, starting 2 cycles after otp_ce; r0_ack at edge 9 with rdata=0xA5, err=0.
- r1 program, addr=0x3FF, wdata=0x3C, prog_en=1, T_PGM=100 -> otp_pgm high exactly 100 cycles; otp_din=0x3C and otp_addr=0x3FF stable from otp_ce rise to fall; r1_ack at edge 105.
- r0 program with prog_en=0 -> r0_ack and err high one edge later, otp_ce/otp_pgm never assert, rdata unchanged.
- r0_req and r1_req both held high, each dropping one cycle after its ack and re-raising -> grants alternate r0, r1, r0, r1; no requester gets two consecutive grants while the other waits.
- Change r0_addr/r0_wdata every cycle during an r0 program -> otp_addr/otp_din hold the values sampled at grant; the non-owner's req is ignored until IDLE.
